// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Instruction/memory handshake and datapath-control bundle
//               between the multi-cycle controller and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       take_branch;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_write;
    logic       branch;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic       illegal;

    modport master (
        output opcode, funct3, take_branch, imem_ready, dmem_ready,
        input  imem_req, ir_write, branch, alu_src_a, alu_src_b, alu_op,
               dmem_req, dmem_we, reg_write, wb_sel, pc_write, pc_src,
               state, illegal
    );

    modport slave (
        input  opcode, funct3, take_branch, imem_ready, dmem_ready,
        output imem_req, ir_write, branch, alu_src_a, alu_src_b, alu_op,
               dmem_req, dmem_we, reg_write, wb_sel, pc_write, pc_src,
               state, illegal
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : FETCH/DECODE/EXEC/MEM/WB control FSM for a multi-cycle RV32I
//               datapath with a sticky illegal-instruction trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    multicycle_ctrl_if.slave   bus
);
    localparam logic [2:0] c_fetch  = 3'b000;
    localparam logic [2:0] c_decode = 3'b001;
    localparam logic [2:0] c_exec   = 3'b010;
    localparam logic [2:0] c_mem    = 3'b011;
    localparam logic [2:0] c_wb     = 3'b100;
    localparam logic [2:0] c_trap   = 3'b101;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       r_illegal;
    logic       w_legal;
    logic       w_is_store;

    logic       w_alu_src_a_dec;
    logic       w_alu_src_b_dec;
    logic [1:0] w_alu_op_dec;

    logic       w_imem_req, w_ir_write, w_branch, w_alu_src_a, w_alu_src_b;
    logic [1:0] w_alu_op, w_wb_sel, w_pc_src;
    logic       w_dmem_req, w_dmem_we, w_reg_write, w_pc_write;

    assign w_is_store = (bus.opcode == c_op_store);

    always_comb begin
        w_legal = 1'b0;
        case (bus.opcode)
            c_op_lui, c_op_auipc, c_op_jal, c_op_jalr, c_op_load,
            c_op_store, c_op_imm, c_op_reg, c_op_fence: w_legal = 1'b1;
            c_op_branch: w_legal = !((bus.funct3 == 3'b010) || (bus.funct3 == 3'b011));
            default:     w_legal = 1'b0;
        endcase
    end

    // ALU steering chosen in EXEC and held through MEM/WB so the result stays stable
    always_comb begin
        w_alu_src_a_dec = 1'b0;
        w_alu_src_b_dec = 1'b0;
        w_alu_op_dec    = 2'b00;
        case (bus.opcode)
            c_op_lui:                begin w_alu_op_dec = 2'b11; w_alu_src_b_dec = 1'b1; end
            c_op_auipc:              begin w_alu_src_a_dec = 1'b1; w_alu_src_b_dec = 1'b1; end
            c_op_jal, c_op_jalr,
            c_op_load, c_op_store:   w_alu_src_b_dec = 1'b1;
            c_op_branch:             w_alu_op_dec = 2'b01;
            c_op_imm:                begin w_alu_op_dec = 2'b10; w_alu_src_b_dec = 1'b1; end
            c_op_reg:                w_alu_op_dec = 2'b10;
            default:                 ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= c_fetch;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == c_trap) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_fetch:  w_next_state = bus.imem_ready ? c_decode : c_fetch;
            c_decode: w_next_state = w_legal ? c_exec : c_trap;
            c_exec: begin
                case (bus.opcode)
                    c_op_branch, c_op_fence: w_next_state = c_fetch;
                    c_op_load, c_op_store:   w_next_state = c_mem;
                    default:                 w_next_state = c_wb;
                endcase
            end
            c_mem: begin
                if (bus.dmem_ready) begin
                    w_next_state = w_is_store ? c_fetch : c_wb;
                end
            end
            c_wb:     w_next_state = c_fetch;
            c_trap:   w_next_state = c_trap;
            default:  w_next_state = c_trap;
        endcase
    end

    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_branch    = 1'b0;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 1'b0;
        w_alu_op    = 2'b00;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'b00;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'b00;
        case (r_state)
            c_fetch: begin
                w_imem_req = 1'b1;
                w_ir_write = bus.imem_ready;
            end
            c_exec: begin
                w_alu_src_a = w_alu_src_a_dec;
                w_alu_src_b = w_alu_src_b_dec;
                w_alu_op    = w_alu_op_dec;
                if (bus.opcode == c_op_branch) begin
                    w_branch   = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = bus.take_branch ? 2'b01 : 2'b00;
                end else if (bus.opcode == c_op_fence) begin
                    w_pc_write = 1'b1;
                end
            end
            c_mem: begin
                w_alu_src_a = w_alu_src_a_dec;
                w_alu_src_b = w_alu_src_b_dec;
                w_alu_op    = w_alu_op_dec;
                w_dmem_req  = 1'b1;
                w_dmem_we   = w_is_store;
                w_pc_write  = w_is_store && bus.dmem_ready;
            end
            c_wb: begin
                w_alu_src_a = w_alu_src_a_dec;
                w_alu_src_b = w_alu_src_b_dec;
                w_alu_op    = w_alu_op_dec;
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                if (bus.opcode == c_op_load) begin
                    w_wb_sel = 2'b01;
                end else if ((bus.opcode == c_op_jal) || (bus.opcode == c_op_jalr)) begin
                    w_wb_sel = 2'b10;
                end
                if (bus.opcode == c_op_jal) begin
                    w_pc_src = 2'b01;
                end else if (bus.opcode == c_op_jalr) begin
                    w_pc_src = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Reset gates the decoded strobes directly so they fall without waiting for an edge
    assign bus.imem_req  = rst_n_i & w_imem_req;
    assign bus.ir_write  = rst_n_i & w_ir_write;
    assign bus.branch    = rst_n_i & w_branch;
    assign bus.alu_src_a = rst_n_i & w_alu_src_a;
    assign bus.alu_src_b = rst_n_i & w_alu_src_b;
    assign bus.alu_op    = {2{rst_n_i}} & w_alu_op;
    assign bus.dmem_req  = rst_n_i & w_dmem_req;
    assign bus.dmem_we   = rst_n_i & w_dmem_we;
    assign bus.reg_write = rst_n_i & w_reg_write;
    assign bus.wb_sel    = {2{rst_n_i}} & w_wb_sel;
    assign bus.pc_write  = rst_n_i & w_pc_write;
    assign bus.pc_src    = {2{rst_n_i}} & w_pc_src;
    assign bus.state     = r_state;
    assign bus.illegal   = r_illegal;
endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Table-driven, scoreboarded bench for multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;
    localparam int c_fetch = 0, c_decode = 1, c_exec = 2, c_mem = 3, c_wb = 4, c_trap = 5;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        tk;
        int          iwait;
        int          mwait;
        logic        stray;
        int          lat;
        logic [14:0] trace;
        logic [1:0]  pc_src;
        logic [1:0]  wb_sel;
        int          regw;
        logic [1:0]  aluop;
        logic        srca;
        logic        srcb;
        logic        br;
        logic        is_mem;
        logic        is_store;
    } vec_t;

    logic clk_i;
    logic rst_n_i;
    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int   total;
    int   bad;
    vec_t vecs[15];
    vec_t sb[$];

    logic [15:0] all_outs;
    assign all_outs = {bus.imem_req, bus.ir_write, bus.branch, bus.alu_src_a, bus.alu_src_b,
                       bus.alu_op, bus.dmem_req, bus.dmem_we, bus.reg_write, bus.wb_sel,
                       bus.pc_write, bus.pc_src, bus.illegal};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, fetch_c = 0, mem_c = 0;
        int dm = 0, we = 0, rw = 0, irw = 0, imr = 0;
        int st;
        bit done = 0;
        logic [14:0] trace = '0;
        logic [1:0] pcs = 0, wbs = 0, aop = 0;
        logic sa = 0, sbb = 0, br = 0;
        vec_t e;
        string nm;
        sb.push_back(v);
        bus.opcode = v.op; bus.funct3 = v.f3; bus.take_branch = v.tk;
        while (!done && cyc < 40) begin
            st = int'(bus.state);
            bus.imem_ready = (st == c_fetch) ? (fetch_c >= v.iwait) : v.stray;
            bus.dmem_ready = (st == c_mem)   ? (mem_c >= v.mwait)   : v.stray;
            #1;
            cyc++;
            trace = {trace[11:0], bus.state};
            if (st == c_fetch) fetch_c++;
            if (st == c_mem) mem_c++;
            if (st == c_exec) begin
                aop = bus.alu_op; sa = bus.alu_src_a; sbb = bus.alu_src_b; br = bus.branch;
            end
            dm += int'(bus.dmem_req); we += int'(bus.dmem_we); rw += int'(bus.reg_write);
            irw += int'(bus.ir_write); imr += int'(bus.imem_req);
            if (bus.pc_write) begin
                done = 1; pcs = bus.pc_src; wbs = bus.wb_sel;
            end
            @(posedge clk_i); #1;
        end
        bus.imem_ready = 0; bus.dmem_ready = 0;
        nm = $sformatf("v%0d", idx);
        e = sb.pop_front();
        if (!done) begin
            chk({nm, "_retire_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, cyc, e.lat + e.iwait + e.mwait);
            chk({nm, "_trace"}, int'(trace), int'(e.trace));
            chk({nm, "_pc_src"}, int'(pcs), int'(e.pc_src));
            chk({nm, "_wb_sel"}, int'(wbs), int'(e.wb_sel));
            chk({nm, "_reg_write_cnt"}, rw, e.regw);
            chk({nm, "_alu_op"}, int'(aop), int'(e.aluop));
            chk({nm, "_src_a"}, int'(sa), int'(e.srca));
            chk({nm, "_src_b"}, int'(sbb), int'(e.srcb));
            chk({nm, "_branch"}, int'(br), int'(e.br));
            chk({nm, "_dmem_req_cnt"}, dm, e.is_mem ? e.mwait + 1 : 0);
            chk({nm, "_dmem_we_cnt"}, we, e.is_store ? e.mwait + 1 : 0);
            chk({nm, "_ir_write_cnt"}, irw, 1);
            chk({nm, "_imem_req_cnt"}, imr, e.iwait + 1);
        end
    endtask

    task automatic apply_reset_and_release(input string nm);
        rst_n_i = 1'b0;
        bus.imem_ready = 0; bus.dmem_ready = 0;
        #1;
        chk({nm, "_rst_outs"}, int'(all_outs), 0);
        chk({nm, "_rst_state"}, int'(bus.state), c_fetch);
        @(posedge clk_i); #3;
        chk({nm, "_rst_hold_outs"}, int'(all_outs), 0);
        rst_n_i = 1'b1;
        #1;
        chk({nm, "_restart_imem_req"}, int'(bus.imem_req), 1);
        @(posedge clk_i); #1;
        chk({nm, "_restart_state"}, int'(bus.state), c_fetch);
    endtask

    task automatic reset_mid(input logic [6:0] op, input int target, input string nm);
        int cyc = 0;
        bus.opcode = op; bus.funct3 = 3'b000; bus.take_branch = 0;
        while (int'(bus.state) != target && cyc < 20) begin
            bus.imem_ready = (int'(bus.state) == c_fetch);
            bus.dmem_ready = 0;
            cyc++;
            @(posedge clk_i); #1;
        end
        bus.imem_ready = 0;
        chk({nm, "_reached"}, int'(bus.state), target);
        #2;
        chk({nm, "_strobes_before"}, int'(all_outs != 0), 1);
        apply_reset_and_release(nm);
    endtask

    task automatic trap_seq(input logic [6:0] op, input logic [2:0] f3, input string nm);
        int cyc = 0, good = 0;
        bus.opcode = op; bus.funct3 = f3; bus.take_branch = 0;
        while (int'(bus.state) != c_trap && cyc < 20) begin
            bus.imem_ready = (int'(bus.state) == c_fetch);
            cyc++;
            @(posedge clk_i); #1;
        end
        chk({nm, "_cycles_to_trap"}, cyc, 2);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ready = 1; bus.dmem_ready = 1;
            #1;
            if (int'(bus.state) == c_trap && bus.illegal === 1'b1 && all_outs[15:1] == 0) good++;
            @(posedge clk_i); #1;
        end
        chk({nm, "_trap_hold"}, good, 20);
        apply_reset_and_release(nm);
        chk({nm, "_illegal_cleared"}, int'(bus.illegal), 0);
    endtask

    initial begin
        total = 0; bad = 0;
        //          op          f3   tk iw mw st lat trace                               pc    wb    rw alu   a  b  br m  s
        vecs[0]  = '{7'b0110011, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0};
        vecs[1]  = '{7'b0110011, 3'd0, 0, 2, 0, 1, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0};
        vecs[2]  = '{7'b1100011, 3'd0, 1, 0, 0, 0, 3, {3'd0,3'd0,3'd0,3'd1,3'd2}, 2'b01, 2'b00, 0, 2'b01, 0, 0, 1, 0, 0};
        vecs[3]  = '{7'b1100011, 3'd0, 0, 0, 0, 0, 3, {3'd0,3'd0,3'd0,3'd1,3'd2}, 2'b00, 2'b00, 0, 2'b01, 0, 0, 1, 0, 0};
        vecs[4]  = '{7'b1100011, 3'd4, 1, 0, 0, 1, 3, {3'd0,3'd0,3'd0,3'd1,3'd2}, 2'b01, 2'b00, 0, 2'b01, 0, 0, 1, 0, 0};
        vecs[5]  = '{7'b0000011, 3'd2, 0, 0, 3, 0, 5, {3'd3,3'd3,3'd3,3'd3,3'd4}, 2'b00, 2'b01, 1, 2'b00, 0, 1, 0, 1, 0};
        vecs[6]  = '{7'b0000011, 3'd2, 0, 0, 0, 0, 5, {3'd0,3'd1,3'd2,3'd3,3'd4}, 2'b00, 2'b01, 1, 2'b00, 0, 1, 0, 1, 0};
        vecs[7]  = '{7'b0100011, 3'd2, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd3}, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 1, 1};
        vecs[8]  = '{7'b0100011, 3'd2, 0, 0, 2, 1, 4, {3'd1,3'd2,3'd3,3'd3,3'd3}, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 1, 1};
        vecs[9]  = '{7'b0010011, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b00, 2'b00, 1, 2'b10, 0, 1, 0, 0, 0};
        vecs[10] = '{7'b0110111, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b00, 2'b00, 1, 2'b11, 0, 1, 0, 0, 0};
        vecs[11] = '{7'b0010111, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b00, 2'b00, 1, 2'b00, 1, 1, 0, 0, 0};
        vecs[12] = '{7'b1101111, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b01, 2'b10, 1, 2'b00, 0, 1, 0, 0, 0};
        vecs[13] = '{7'b1100111, 3'd0, 0, 0, 0, 0, 4, {3'd0,3'd0,3'd1,3'd2,3'd4}, 2'b10, 2'b10, 1, 2'b00, 0, 1, 0, 0, 0};
        vecs[14] = '{7'b0001111, 3'd0, 0, 0, 0, 0, 3, {3'd0,3'd0,3'd0,3'd1,3'd2}, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0};

        rst_n_i = 1'b0;
        bus.opcode = '0; bus.funct3 = '0; bus.take_branch = 0;
        bus.imem_ready = 0; bus.dmem_ready = 0;
        @(posedge clk_i); @(posedge clk_i); #3;
        apply_reset_and_release("por");

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        trap_seq(7'b1110011, 3'd0, "trap_system");
        trap_seq(7'b1100011, 3'd2, "trap_br010");
        trap_seq(7'b1100011, 3'd3, "trap_br011");

        reset_mid(7'b1100111, c_wb, "jalr_wb_reset");
        reset_mid(7'b0000011, c_mem, "lw_mem_reset");
        run_vec(0, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
